// File: rtl/equiv_stim_ctrl.sv
// equiv_stim_ctrl
//
// Sequences one bounded random-stimulus equivalence run between a gold
// netlist and a gate netlist. Both instances receive the same LFSR-driven
// stimulus. Their y outputs are compared every RUN cycle once the warm-up
// window has elapsed. The block reports pass/fail together with the first
// failing cycle and the difference vector.
//
// Optional feature: define EQUIV_STIM_SIGNATURE_EN to build a 32-bit MISR
// over y_gold (signature output). When the macro is undefined, signature is
// tied to 0 and no MISR logic exists.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   start       begin a run (accepted in IDLE/DONE/FAIL)
//   abort       cancel the run (effective in RUN)
//   seed        LFSR seed, captured with the accepted start (0 maps to 1)
//   y_gold      output of the gold instance
//   y_gate      output of the gate instance
//   stim_o      registered stimulus bus to both instances
//   busy        high while running
//   pass        run completed without mismatch
//   fail        run stopped on a mismatch
//   fail_cycle  cycle counter value at the first mismatch
//   fail_xor    y_gold ^ y_gate at the first mismatch
//   signature   MISR of y_gold over the compared cycles (0 if not built)
module equiv_stim_ctrl #(
    parameter int STIM_W = 86,
    parameter int Y_W    = 81,
    parameter int CNT_W  = 16,
    parameter int CYCLES = 1024,
    parameter int WARMUP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       seed,
    input  logic [Y_W-1:0]    y_gold,
    input  logic [Y_W-1:0]    y_gate,
    output logic [STIM_W-1:0] stim_o,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [CNT_W-1:0]  fail_cycle,
    output logic [Y_W-1:0]    fail_xor,
    output logic [31:0]       signature
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_FAIL = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_WARM = CNT_W'(WARMUP);

    localparam int NREP = (STIM_W + 31) / 32;
    localparam int NCHK = (Y_W + 31) / 32;

    logic [1:0]       state;
    logic [31:0]      lfsr;
    logic [31:0]      lfsr_nxt;
    logic [31:0]      seed_eff;
    logic [CNT_W-1:0] cnt;
    logic             mismatch;

    // 32-bit Fibonacci step, taps 31/21/1/0; shared by the LFSR and the MISR.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction

    // Replicate the LFSR word across the stimulus bus, bit 0 = v[0].
    function automatic logic [STIM_W-1:0] replicate(input logic [31:0] v);
        logic [NREP*32-1:0] r;
        r = {NREP{v}};
        return r[STIM_W-1:0];
    endfunction

    // XOR of the 32-bit chunks of y, top chunk zero-padded.
    function automatic logic [31:0] fold32(input logic [Y_W-1:0] y);
        logic [NCHK*32-1:0] pad;
        logic [31:0]        acc;
        pad = '0;
        pad[Y_W-1:0] = y;
        acc = '0;
        for (int j = 0; j < NCHK; j++) begin
            acc = acc ^ pad[j*32 +: 32];
        end
        return acc;
    endfunction

    assign lfsr_nxt = lfsr_step(lfsr);
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    assign seed_eff = (seed == 32'd0) ? 32'd1 : seed;
    assign mismatch = (y_gold != y_gate) && (cnt >= CNT_WARM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            lfsr       <= 32'd1;
            cnt        <= '0;
            stim_o     <= '0;
            busy       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            fail_cycle <= '0;
            fail_xor   <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    // abort beats mismatch, mismatch beats completion
                    if (abort) begin
                        state      <= S_IDLE;
                        cnt        <= '0;
                        stim_o     <= '0;
                        busy       <= 1'b0;
                        pass       <= 1'b0;
                        fail       <= 1'b0;
                        fail_cycle <= '0;
                        fail_xor   <= '0;
                    end else if (mismatch) begin
                        state      <= S_FAIL;
                        busy       <= 1'b0;
                        fail       <= 1'b1;
                        fail_cycle <= cnt;
                        fail_xor   <= y_gold ^ y_gate;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        pass  <= 1'b1;
                    end else begin
                        cnt    <= cnt + 1'b1;
                        lfsr   <= lfsr_nxt;
                        stim_o <= replicate(lfsr_nxt);
                    end
                end
                default: begin
                    // IDLE, DONE, FAIL: stim_o holds until a new run starts
                    if (start) begin
                        state      <= S_RUN;
                        lfsr       <= seed_eff;
                        cnt        <= '0;
                        stim_o     <= replicate(seed_eff);
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        fail       <= 1'b0;
                        fail_cycle <= '0;
                        fail_xor   <= '0;
                    end
                end
            endcase
        end
    end

`ifdef EQUIV_STIM_SIGNATURE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            signature <= '0;
        end else if (state == S_RUN) begin
            if (abort) begin
                signature <= '0;
            end else if (cnt >= CNT_WARM) begin
                signature <= lfsr_step(signature) ^ fold32(y_gold);
            end
        end else if (start) begin
            signature <= '0;
        end
    end
`else
    assign signature = '0;
`endif

endmodule

// File: tb/tb_equiv_stim_ctrl.sv
// Scoreboard bench for equiv_stim_ctrl (CYCLES=16, WARMUP=4).
// The stimulus process pushes the expected end-of-run record for each run;
// the monitor pops and compares it when busy falls.
module tb_equiv_stim_ctrl;
    localparam int STIM_W = 86;
    localparam int Y_W    = 81;
    localparam int CNT_W  = 16;
    localparam int CYCLES = 16;
    localparam int WARMUP = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [31:0]       seed;
    logic [Y_W-1:0]    y_gold;
    logic [Y_W-1:0]    y_gate;
    logic [Y_W-1:0]    flip;
    logic [STIM_W-1:0] stim_o;
    logic              busy;
    logic              pass;
    logic              fail;
    logic [CNT_W-1:0]  fail_cycle;
    logic [Y_W-1:0]    fail_xor;
    logic [31:0]       signature;

    assign y_gate = y_gold ^ flip;

    equiv_stim_ctrl #(
        .STIM_W(STIM_W), .Y_W(Y_W), .CNT_W(CNT_W),
        .CYCLES(CYCLES), .WARMUP(WARMUP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed),
        .y_gold(y_gold), .y_gate(y_gate), .stim_o(stim_o), .busy(busy),
        .pass(pass), .fail(fail), .fail_cycle(fail_cycle),
        .fail_xor(fail_xor), .signature(signature)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             p;
        logic             f;
        logic [CNT_W-1:0] fc;
        logic [Y_W-1:0]   fx;
        logic [31:0]      sig;
        int               blen;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [31:0] m_step(input logic [31:0] v);
        return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction

    function automatic logic [STIM_W-1:0] m_rep(input logic [31:0] v);
        logic [95:0] r;
        r = {3{v}};
        return r[STIM_W-1:0];
    endfunction

    // Expected MISR after n updates with y_gold fixed at 1 (fold32 = 1).
    function automatic logic [31:0] m_sig(input int n);
        logic [31:0] s;
        s = 32'd0;
`ifdef EQUIV_STIM_SIGNATURE_EN
        for (int i = 0; i < n; i++) s = m_step(s) ^ 32'd1;
`endif
        return s;
    endfunction

    task automatic push_exp(input logic p, input logic f, input int fc, input int fx_bit,
                            input int nsig, input int blen);
        exp_t e;
        e.p    = p;
        e.f    = f;
        e.fc   = CNT_W'(fc);
        e.fx   = (fx_bit < 0) ? '0 : (Y_W'(1) << fx_bit);
        e.sig  = m_sig(nsig);
        e.blen = blen;
        sb.push_back(e);
    endtask

    // Monitor: counts busy cycles and checks the outcome when busy falls.
    logic prev_busy = 1'b0;
    int   blen_cnt  = 0;
    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1) begin
            blen_cnt++;
        end else if (prev_busy === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_end: run ended with no expected record, got pass=%0b fail=%0b", pass, fail);
            end else begin
                e = sb.pop_front();
                chk("end_pass",       128'(pass),       128'(e.p));
                chk("end_fail",       128'(fail),       128'(e.f));
                chk("end_fail_cycle", 128'(fail_cycle), 128'(e.fc));
                chk("end_fail_xor",   128'(fail_xor),   128'(e.fx));
                chk("end_signature",  128'(signature),  128'(e.sig));
                chk("end_busy_len",   128'(blen_cnt),   128'(e.blen));
            end
            blen_cnt = 0;
        end
        prev_busy = busy;
    end

    // One run: start with sd, then drive len RUN cycles; event columns give
    // the cnt value at which each disturbance is applied (-1 = never).
    task automatic do_run(input logic [31:0] sd, input int flip_at, input int abort_at,
                          input int rst_at, input int start_at, input int len,
                          output logic [31:0] last_lfsr);
        logic [31:0] m;
        @(negedge clk);
        start = 1'b1;
        seed  = sd;
        @(negedge clk);
        start = 1'b0;
        m = (sd == 32'd0) ? 32'd1 : sd;
        last_lfsr = m;
        for (int c = 0; c < len; c++) begin
            chk($sformatf("stim_c%0d", c), 128'(stim_o), 128'(m_rep(m)));
            last_lfsr = m;
            m = m_step(m);
            flip  = (c == flip_at) ? Y_W'(32'h20) : '0;
            abort = (c == abort_at);
            rst   = (c == rst_at);
            start = (c == start_at);
            if (c == start_at) seed = 32'hDEADBEEF;
            @(negedge clk);
        end
        flip  = '0;
        abort = 1'b0;
        rst   = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] last;
        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        seed   = 32'd0;
        y_gold = Y_W'(1);
        flip   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy",       128'(busy),       128'(0));
        chk("rst_pass",       128'(pass),       128'(0));
        chk("rst_fail",       128'(fail),       128'(0));
        chk("rst_fail_cycle", 128'(fail_cycle), 128'(0));
        chk("rst_fail_xor",   128'(fail_xor),   128'(0));
        chk("rst_signature",  128'(signature),  128'(0));
        chk("rst_stim",       128'(stim_o),     128'(0));

        // clean pass run
        push_exp(1'b1, 1'b0, 0, -1, CYCLES - WARMUP, CYCLES);
        do_run(32'd1, -1, -1, -1, -1, CYCLES, last);
        chk("done_stim_hold", 128'(stim_o), 128'(m_rep(last)));
        chk("done_busy",      128'(busy),   128'(0));

        // late mismatch on bit 5 at cnt 9
        push_exp(1'b0, 1'b1, 9, 5, 9 - WARMUP + 1, 10);
        do_run(32'h1234_5678, 9, -1, -1, -1, 10, last);
        chk("fail_stim_hold", 128'(stim_o), 128'(m_rep(last)));

        // mismatch inside warm-up window is ignored
        push_exp(1'b1, 1'b0, 0, -1, CYCLES - WARMUP, CYCLES);
        do_run(32'hA5A5_0F0F, 2, -1, -1, -1, CYCLES, last);

        // zero seed behaves as seed 1
        push_exp(1'b1, 1'b0, 0, -1, CYCLES - WARMUP, CYCLES);
        do_run(32'd0, -1, -1, -1, -1, CYCLES, last);

        // abort together with a mismatch at cnt 6
        push_exp(1'b0, 1'b0, 0, -1, 0, 7);
        do_run(32'hCAFE_0001, 6, 6, -1, -1, 7, last);
        chk("abort_stim_zero", 128'(stim_o), 128'(0));

        // start while busy is ignored; stimulus sequence continues
        push_exp(1'b1, 1'b0, 0, -1, CYCLES - WARMUP, CYCLES);
        do_run(32'h0000_BEEF, -1, -1, -1, 3, CYCLES, last);

        // reset mid-run at cnt 7
        push_exp(1'b0, 1'b0, 0, -1, 0, 8);
        do_run(32'h7777_1111, -1, -1, 7, -1, 8, last);
        chk("midrst_busy",      128'(busy),      128'(0));
        chk("midrst_pass",      128'(pass),      128'(0));
        chk("midrst_stim",      128'(stim_o),    128'(0));
        chk("midrst_signature", 128'(signature), 128'(0));

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 128'(sb.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Safety bound on total run time.
    initial begin
        #100000;
        $display("FAIL timeout: bench exceeded time limit, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end
endmodule
